sprite_plotter: RTL

- Parametrised successor to the single-object pattern drawer.
- Draws one of N_OBJ fixed-size sprites, read from an external synchronous sprite memory, at a latched (x,y) position.
- Start/busy/done handshake, screen-edge clipping and an erase mode that fills the sprite rectangle with a background colour.
- Sits between game control logic and the DESim VGA pixel interface (VGA_X/VGA_Y/VGA_COLOR/plot).

---
 rtl/sprite_plotter.sv | 112 +++++++++++
 1 files changed

// File: rtl/sprite_plotter.sv
`timescale 1ns/1ps
// sprite_plotter: streams an OBJ_W x OBJ_H sprite from synchronous memory to the VGA pixel port with clipping and erase.
// Optional macro TRANSPARENT_EN adds KEY_COLOR; pixels of that colour are not plotted outside erase mode.
module sprite_plotter #(
   parameter int OBJ_W    = 8,
   parameter int OBJ_H    = 8,
   parameter int N_OBJ    = 2,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOR_W  = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0,
`ifdef TRANSPARENT_EN
   parameter logic [COLOR_W-1:0] KEY_COLOR = '0,
`endif
   localparam int XCW = $clog2(OBJ_W),
   localparam int YCW = $clog2(OBJ_H),
   localparam int OW  = (N_OBJ > 1) ? $clog2(N_OBJ) : 0,
   localparam int SW  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
   localparam int AW  = OW + YCW + XCW
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               start,
   input  logic               erase,
   input  logic [X_W-1:0]     x_in,
   input  logic [Y_W-1:0]     y_in,
   input  logic [SW-1:0]      obj_sel,
   output logic [AW-1:0]      mem_addr,
   input  logic [COLOR_W-1:0] mem_q,
   output logic               busy,
   output logic               done,
   output logic [X_W-1:0]     VGA_X,
   output logic [Y_W-1:0]     VGA_Y,
   output logic [COLOR_W-1:0] VGA_COLOR,
   output logic               plot
);
   typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
   state_t             r_state, w_next;
   logic [XCW-1:0]     r_xc;
   logic [YCW-1:0]     r_yc;
   logic [X_W-1:0]     r_x, r_vga_x;
   logic [Y_W-1:0]     r_y, r_vga_y;
   logic [SW-1:0]      r_obj;
   logic               r_erase, r_plot;
   logic [X_W:0]       w_xs;
   logic [Y_W:0]       w_ys;
   logic               w_clip, w_last;

   // with a single sprite the object field has zero width; the cast drops it
   assign mem_addr  = AW'({r_obj, r_yc, r_xc});
   assign w_xs      = {1'b0, r_x} + (X_W+1)'(r_xc);
   assign w_ys      = {1'b0, r_y} + (Y_W+1)'(r_yc);
   assign w_clip    = (w_xs >= (X_W+1)'(SCREEN_W)) || (w_ys >= (Y_W+1)'(SCREEN_H));
   assign w_last    = (r_xc == XCW'(OBJ_W-1)) && (r_yc == YCW'(OBJ_H-1));
   assign busy      = r_state != IDLE;
   assign done      = r_state == DONE;
   assign VGA_X     = r_vga_x;
   assign VGA_Y     = r_vga_y;
   assign VGA_COLOR = r_erase ? BG_COLOR : mem_q;
`ifdef TRANSPARENT_EN
   assign plot      = r_plot && (r_erase || mem_q != KEY_COLOR);
`else
   assign plot      = r_plot;
`endif

   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  w_next = start ? DRAW : IDLE;
         DRAW:  w_next = w_last ? FLUSH : DRAW;
         FLUSH: w_next = DONE;
         DONE:  w_next = IDLE;
      endcase
   end

   // memory data arrives one cycle after its address, matching the registered coordinates
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) begin
         r_xc    <= '0;
         r_yc    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_obj   <= '0;
         r_erase <= 1'b0;
         r_vga_x <= '0;
         r_vga_y <= '0;
         r_plot  <= 1'b0;
      end else begin
         r_plot <= 1'b0;
         if (r_state == IDLE && start) begin
            r_x     <= x_in;
            r_y     <= y_in;
            r_obj   <= obj_sel;
            r_erase <= erase;
            r_xc    <= '0;
            r_yc    <= '0;
         end
         if (r_state == DRAW) begin
            r_xc    <= r_xc + 1'b1;
            if (r_xc == XCW'(OBJ_W-1)) r_yc <= r_yc + 1'b1;
            r_vga_x <= w_xs[X_W-1:0];
            r_vga_y <= w_ys[Y_W-1:0];
            r_plot  <= !w_clip;
         end
      end
endmodule
